// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: walks the shared datapath through fetch/decode/execute/memory/write-back.
// Optional illegal-opcode trap state enabled by defining MULTICYCLE_TRAP_EN.
module multicycle_control (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [5:0] opcode_in,
  input  logic       memReady_in,
  output logic       pcWrite_out,
  output logic       pcWriteCond_out,
  output logic       iorD_out,
  output logic       memRead_out,
  output logic       memWrite_out,
  output logic       irWrite_out,
  output logic       memtoReg_out,
  output logic       regDst_out,
  output logic       regWrite_out,
  output logic       aluSrcA_out,
  output logic [1:0] aluSrcB_out,
  output logic [1:0] aluOp_out,
  output logic [1:0] pcSource_out,
  output logic       instrDone_out,
  output logic [3:0] state_out,
  output logic       exception_out
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    RWB      = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    ADDIU_EX = 4'd11,
    ADDIU_WB = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state;
  state_t next_state;
  logic   legal_op;

  always_comb begin
    case (opcode_in)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDIU, OP_LW, OP_SW: legal_op = 1'b1;
      default:                                        legal_op = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in)
      state <= IDLE;
    else
      state <= next_state;
  end

  assign state_out = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = FETCH;
      FETCH:    next_state = memReady_in ? DECODE : FETCH;
      DECODE: begin
        case (opcode_in)
          OP_RTYPE:     next_state = EXECUTE;
          OP_J:         next_state = JUMP;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDIU:     next_state = ADDIU_EX;
          OP_LW, OP_SW: next_state = MEMADR;
`ifdef MULTICYCLE_TRAP_EN
          default:      next_state = TRAP;
`else
          default:      next_state = FETCH;
`endif
        endcase
      end
      MEMADR:   next_state = (opcode_in == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = memReady_in ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = memReady_in ? FETCH : MEMWRITE;
      EXECUTE:  next_state = RWB;
      RWB:      next_state = FETCH;
      BRANCH:   next_state = FETCH;
      JUMP:     next_state = FETCH;
      ADDIU_EX: next_state = ADDIU_WB;
      ADDIU_WB: next_state = FETCH;
`ifdef MULTICYCLE_TRAP_EN
      TRAP:     next_state = TRAP;
`else
      TRAP:     next_state = IDLE;
`endif
      default:  next_state = IDLE;
    endcase
  end

  // Moore outputs from state; FETCH, MEMWRITE and illegal DECODE add Mealy terms.
  always_comb begin
    pcWrite_out     = 1'b0;
    pcWriteCond_out = 1'b0;
    iorD_out        = 1'b0;
    memRead_out     = 1'b0;
    memWrite_out    = 1'b0;
    irWrite_out     = 1'b0;
    memtoReg_out    = 1'b0;
    regDst_out      = 1'b0;
    regWrite_out    = 1'b0;
    aluSrcA_out     = 1'b0;
    aluSrcB_out     = 2'b00;
    aluOp_out       = 2'b00;
    pcSource_out    = 2'b00;
    instrDone_out   = 1'b0;
    exception_out   = 1'b0;
    case (state)
      FETCH: begin
        memRead_out = 1'b1;
        aluSrcB_out = 2'b01;
        irWrite_out = memReady_in;
        pcWrite_out = memReady_in;
      end
      DECODE: begin
        aluSrcB_out = 2'b11;
`ifndef MULTICYCLE_TRAP_EN
        instrDone_out = ~legal_op;
`endif
      end
      MEMADR: begin
        aluSrcA_out = 1'b1;
        aluSrcB_out = 2'b10;
      end
      MEMREAD: begin
        memRead_out = 1'b1;
        iorD_out    = 1'b1;
      end
      MEMWB: begin
        regWrite_out  = 1'b1;
        memtoReg_out  = 1'b1;
        instrDone_out = 1'b1;
      end
      MEMWRITE: begin
        memWrite_out  = 1'b1;
        iorD_out      = 1'b1;
        instrDone_out = memReady_in;
      end
      EXECUTE: begin
        aluSrcA_out = 1'b1;
        aluOp_out   = 2'b10;
      end
      RWB: begin
        regWrite_out  = 1'b1;
        regDst_out    = 1'b1;
        instrDone_out = 1'b1;
      end
      BRANCH: begin
        aluSrcA_out     = 1'b1;
        aluOp_out       = 2'b01;
        pcWriteCond_out = 1'b1;
        pcSource_out    = 2'b01;
        instrDone_out   = 1'b1;
      end
      JUMP: begin
        pcWrite_out   = 1'b1;
        pcSource_out  = 2'b10;
        instrDone_out = 1'b1;
      end
      ADDIU_EX: begin
        aluSrcA_out = 1'b1;
        aluSrcB_out = 2'b10;
      end
      ADDIU_WB: begin
        regWrite_out  = 1'b1;
        instrDone_out = 1'b1;
      end
`ifdef MULTICYCLE_TRAP_EN
      TRAP:     exception_out = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: expands each instruction into its expected cycle list and compares per cycle.
// Also covers CPI, async reset mid-instruction and (with MULTICYCLE_TRAP_EN) the trap state.
module tb_multicycle_control;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4,
                 S_MEMWB = 5, S_MEMWRITE = 6, S_EXECUTE = 7, S_RWB = 8, S_BRANCH = 9,
                 S_JUMP = 10, S_ADDIU_EX = 11, S_ADDIU_WB = 12, S_TRAP = 13;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_ADDIU = 6'b001001, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BAD = 6'b111111;

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic [5:0] opcode_in;
  logic       memReady_in;
  logic       pcWrite_out, pcWriteCond_out, iorD_out, memRead_out, memWrite_out, irWrite_out;
  logic       memtoReg_out, regDst_out, regWrite_out, aluSrcA_out, instrDone_out, exception_out;
  logic [1:0] aluSrcB_out, aluOp_out, pcSource_out;
  logic [3:0] state_out;
  logic [17:0] dutOuts;

  typedef struct {
    logic [3:0]  st;
    logic [5:0]  op;
    bit          rdy;
    logic [17:0] outs;
  } cyc_t;

  cyc_t expQ[$];
  int checks = 0;
  int errors = 0;
  int doneSeen = 0;
  int doneExpected = 0;

  multicycle_control dut (
    .clock_in(clock_in), .reset_in(reset_in), .opcode_in(opcode_in), .memReady_in(memReady_in),
    .pcWrite_out(pcWrite_out), .pcWriteCond_out(pcWriteCond_out), .iorD_out(iorD_out),
    .memRead_out(memRead_out), .memWrite_out(memWrite_out), .irWrite_out(irWrite_out),
    .memtoReg_out(memtoReg_out), .regDst_out(regDst_out), .regWrite_out(regWrite_out),
    .aluSrcA_out(aluSrcA_out), .aluSrcB_out(aluSrcB_out), .aluOp_out(aluOp_out),
    .pcSource_out(pcSource_out), .instrDone_out(instrDone_out), .state_out(state_out),
    .exception_out(exception_out)
  );

  always #5 clock_in = ~clock_in;

  assign dutOuts = {pcWrite_out, pcWriteCond_out, iorD_out, memRead_out, memWrite_out, irWrite_out,
                    memtoReg_out, regDst_out, regWrite_out, aluSrcA_out, aluSrcB_out, aluOp_out,
                    pcSource_out, instrDone_out, exception_out};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] packOuts(bit pcw, bit pcwc, bit iord, bit mr, bit mw, bit irw,
                                           bit m2r, bit rdst, bit rw, bit asa, logic [1:0] asb,
                                           logic [1:0] aop, logic [1:0] psrc, bit done, bit exc);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, exc};
  endfunction

  // Expected datapath controls for a state, straight from the control table.
  function automatic logic [17:0] expOuts(int st, bit rdy, bit illegal);
    case (st)
      S_FETCH:    return packOuts(rdy,0,0,1,0,rdy,0,0,0,0,2'b01,2'b00,2'b00,0,0);
      S_DECODE:   return packOuts(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,illegal,0);
      S_MEMADR:   return packOuts(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
      S_MEMREAD:  return packOuts(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
      S_MEMWB:    return packOuts(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
      S_MEMWRITE: return packOuts(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,rdy,0);
      S_EXECUTE:  return packOuts(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
      S_RWB:      return packOuts(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
      S_BRANCH:   return packOuts(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
      S_JUMP:     return packOuts(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
      S_ADDIU_EX: return packOuts(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
      S_ADDIU_WB: return packOuts(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);
      S_TRAP:     return packOuts(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);
      default:    return 18'd0;
    endcase
  endfunction

  task automatic pushCycle(int st, logic [5:0] op, bit sampled, bit rdy, bit illegal);
    cyc_t c;
    c.st   = 4'(st);
    c.op   = sampled ? op : 6'($urandom);
    c.rdy  = rdy;
    c.outs = expOuts(st, rdy, illegal);
    expQ.push_back(c);
  endtask

  task automatic pushMem(int st, logic [5:0] op);
    int k = $urandom_range(0, 2);
    repeat (k) pushCycle(st, op, 0, 0, 0);
    pushCycle(st, op, 0, 1, 0);
  endtask

  task automatic pushOther(int st, logic [5:0] op, bit sampled, bit illegal);
    pushCycle(st, op, sampled, 1'($urandom_range(0, 1)), illegal);
  endtask

  // One instruction expands into fetch, decode and its opcode-specific tail.
  task automatic modelInstr(logic [5:0] op);
    bit legal = (op == OP_R) || (op == OP_J) || (op == OP_BEQ) || (op == OP_ADDIU) ||
                (op == OP_LW) || (op == OP_SW);
    pushMem(S_FETCH, op);
    pushOther(S_DECODE, op, 1, !legal);
    doneExpected++;
    case (op)
      OP_R:     begin pushOther(S_EXECUTE, op, 0, 0); pushOther(S_RWB, op, 0, 0); end
      OP_J:     pushOther(S_JUMP, op, 0, 0);
      OP_BEQ:   pushOther(S_BRANCH, op, 0, 0);
      OP_ADDIU: begin pushOther(S_ADDIU_EX, op, 0, 0); pushOther(S_ADDIU_WB, op, 0, 0); end
      OP_LW:    begin pushOther(S_MEMADR, op, 1, 0); pushMem(S_MEMREAD, op); pushOther(S_MEMWB, op, 0, 0); end
      OP_SW:    begin pushOther(S_MEMADR, op, 1, 0); pushMem(S_MEMWRITE, op); end
      default:  ;
    endcase
  endtask

  task automatic applyStimulus(cyc_t c);
    opcode_in   = c.op;
    memReady_in = c.rdy;
    @(negedge clock_in);
    checkOutput("state", 32'(state_out), 32'(c.st));
    checkOutput("outs", 32'(dutOuts), 32'(c.outs));
    if (instrDone_out) doneSeen++;
    @(posedge clock_in);
    #1;
  endtask

  task automatic runQueue();
    while (expQ.size() > 0) applyStimulus(expQ.pop_front());
  endtask

  // Count cycles from FETCH back to FETCH, stalling the first memory-phase cycles as asked.
  task automatic measureCpi(string tag, logic [5:0] op, int stalls, int expCycles);
    int n = 0;
    int left = stalls;
    do begin
      opcode_in = op;
      memReady_in = 1'b1;
      if ((state_out == 4'(S_MEMREAD) || state_out == 4'(S_MEMWRITE)) && left > 0) begin
        memReady_in = 1'b0;
        left--;
      end
      @(negedge clock_in);
      n++;
      @(posedge clock_in);
      #1;
    end while (state_out != 4'(S_FETCH) && n < 20);
    checkOutput(tag, 32'(n), 32'(expCycles));
  endtask

  task automatic resetMidLoad();
    int n = 0;
    int rwSeen = 0;
    opcode_in = OP_LW;
    memReady_in = 1'b1;
    while (state_out != 4'(S_MEMREAD) && n < 10) begin
      @(posedge clock_in);
      #1;
      n++;
    end
    checkOutput("reach_memread", 32'(state_out), 32'(S_MEMREAD));
    memReady_in = 1'b0;
    @(negedge clock_in);
    #2 reset_in = 1'b1;
    #1;
    checkOutput("rst_state", 32'(state_out), 32'(S_IDLE));
    checkOutput("rst_outs", 32'(dutOuts), 32'd0);
    memReady_in = 1'b1;
    repeat (2) begin
      @(negedge clock_in);
      if (regWrite_out) rwSeen++;
    end
    checkOutput("rst_no_regwrite", 32'(rwSeen), 32'd0);
    @(posedge clock_in);
    #1 reset_in = 1'b0;
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{OP_R, OP_J, OP_BEQ, OP_ADDIU, OP_LW, OP_SW, OP_BAD, 6'b000001};
    reset_in = 1'b1;
    memReady_in = 1'b1;
    opcode_in = 6'd0;
    repeat (3) begin
      @(negedge clock_in);
      checkOutput("reset_state", 32'(state_out), 32'(S_IDLE));
      checkOutput("reset_outs", 32'(dutOuts), 32'd0);
    end
    @(posedge clock_in);
    #1 reset_in = 1'b0;

    pushCycle(S_IDLE, 6'd0, 0, 1, 0);
    modelInstr(OP_LW);
    modelInstr(OP_SW);
    modelInstr(OP_BEQ);
    modelInstr(OP_J);
    modelInstr(OP_ADDIU);
    modelInstr(OP_R);
`ifndef MULTICYCLE_TRAP_EN
    modelInstr(OP_BAD);
`endif
    for (int i = 0; i < 60; i++) begin
`ifdef MULTICYCLE_TRAP_EN
      modelInstr(ops[$urandom_range(0, 5)]);
`else
      modelInstr(ops[$urandom_range(0, 7)]);
`endif
    end
    runQueue();
    checkOutput("done_pulses", 32'(doneSeen), 32'(doneExpected));

    measureCpi("cpi_j", OP_J, 0, 3);
    measureCpi("cpi_beq", OP_BEQ, 0, 3);
    measureCpi("cpi_rtype", OP_R, 0, 4);
    measureCpi("cpi_addiu", OP_ADDIU, 0, 4);
    measureCpi("cpi_sw", OP_SW, 0, 4);
    measureCpi("cpi_lw", OP_LW, 0, 5);
    measureCpi("cpi_sw_stall2", OP_SW, 2, 6);
    measureCpi("cpi_lw_stall1", OP_LW, 1, 6);

    resetMidLoad();
    pushCycle(S_IDLE, 6'd0, 0, 1, 0);
    modelInstr(OP_LW);
    modelInstr(OP_R);
    runQueue();

`ifdef MULTICYCLE_TRAP_EN
    pushCycle(S_FETCH, 6'd0, 0, 1, 0);
    pushCycle(S_DECODE, OP_BAD, 1, 1, 0);
    repeat (4) pushOther(S_TRAP, 6'd0, 0, 0);
    runQueue();
    reset_in = 1'b1;
    #1;
    checkOutput("trap_reset_state", 32'(state_out), 32'(S_IDLE));
    checkOutput("trap_reset_exc", 32'(exception_out), 32'd0);
    @(posedge clock_in);
    #1 reset_in = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
